arbitro_mux_2a1: RTL and testbench

Shares one DB-bit downstream bus between two requesters (A, B), each with a valid/ready handshake. A round-robin burst arbiter drives the select of an internal 2:1 data mux. A one-entry registered output stage drives the bus. Sits in front of any single-consumer datapath resource that two producers must share.

---
 rtl/arbitro_pkg.sv | 16 +
 rtl/arbitro_rr_2.sv | 113 +++++++++++
 rtl/arbitro_mux_2a1.sv | 69 ++++++
 tb/tb_arbitro_mux_2a1.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared definitions for the two-requester bus arbiter.
//   estado_t : grant state of the arbiter FSM (LIBRE / SERVIR_A / SERVIR_B)
//   SEL_A    : Sel value while A holds the grant
//   SEL_B    : Sel value while B holds the grant (also the idle value)
package arbitro_pkg;

  typedef enum logic [1:0] {
    LIBRE    = 2'd0,
    SERVIR_A = 2'd1,
    SERVIR_B = 2'd2
  } estado_t;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/arbitro_rr_2.sv
// Burst arbiter between two requesters: grant FSM, burst counter and the
// record of which requester was served last.
// Build option: ARBITRO_PRIORIDAD_FIJA_EN selects fixed priority (A over B,
// A not limited by MAX_RAFAGA); undefined gives round-robin bursts.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   valido_a, valido_b  requester valid flags
//   libre_sal           output stage can take a word this cycle
//   estado              current grant state (registered)
//   sel                 registered grant select, SEL_A only in SERVIR_A
module arbitro_rr_2
  import arbitro_pkg::*;
#(
  parameter int MAX_RAFAGA = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    valido_a,
  input  logic    valido_b,
  input  logic    libre_sal,
  output estado_t estado,
  output logic    sel
);

  localparam int CW = $clog2(MAX_RAFAGA + 1);
  // Count value at which the next transfer closes the burst.
  localparam logic [CW-1:0] ULTIMA = CW'(MAX_RAFAGA - 1);

  estado_t       estado_sig;
  logic [CW-1:0] cuenta;
  logic [CW-1:0] cuenta_sig;
  logic          xfer_b;

`ifndef ARBITRO_PRIORIDAD_FIJA_EN
  logic ultimo_a;
  logic ultimo_a_sig;
  logic xfer_a;
  assign xfer_a = (estado == SERVIR_A) & valido_a & libre_sal;
`endif

  assign xfer_b = (estado == SERVIR_B) & valido_b & libre_sal;

  always_comb begin
    estado_sig = estado;
    cuenta_sig = cuenta;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
    ultimo_a_sig = ultimo_a;
`endif
    case (estado)
      LIBRE: begin
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
        if (valido_a)      estado_sig = SERVIR_A;
        else if (valido_b) estado_sig = SERVIR_B;
`else
        // On a tie the requester served last yields.
        if (valido_a && valido_b) estado_sig = ultimo_a ? SERVIR_B : SERVIR_A;
        else if (valido_a)        estado_sig = SERVIR_A;
        else if (valido_b)        estado_sig = SERVIR_B;
`endif
      end
      SERVIR_A: begin
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
        // A keeps the bus for as long as it stays valid.
        if (!valido_a) estado_sig = valido_b ? SERVIR_B : LIBRE;
`else
        if (!valido_a || (xfer_a && cuenta == ULTIMA)) begin
          cuenta_sig   = '0;
          ultimo_a_sig = 1'b1;
          if (valido_b)      estado_sig = SERVIR_B;
          else if (valido_a) estado_sig = SERVIR_A;
          else               estado_sig = LIBRE;
        end else if (xfer_a) begin
          cuenta_sig = cuenta + 1'b1;
        end
`endif
      end
      SERVIR_B: begin
        // Same hand-over rule in both modes: A is the "other" requester.
        if (!valido_b || (xfer_b && cuenta == ULTIMA)) begin
          cuenta_sig = '0;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
          ultimo_a_sig = 1'b0;
`endif
          if (valido_a)      estado_sig = SERVIR_A;
          else if (valido_b) estado_sig = SERVIR_B;
          else               estado_sig = LIBRE;
        end else if (xfer_b) begin
          cuenta_sig = cuenta + 1'b1;
        end
      end
      default: estado_sig = LIBRE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= LIBRE;
      sel    <= SEL_B;
      cuenta <= '0;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
      ultimo_a <= 1'b0;
`endif
    end else begin
      estado <= estado_sig;
      sel    <= (estado_sig == SERVIR_A) ? SEL_A : SEL_B;
      cuenta <= cuenta_sig;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
      ultimo_a <= ultimo_a_sig;
`endif
    end
  end

endmodule

// File: rtl/arbitro_mux_2a1.sv
// Shares one DB-bit downstream bus between requesters A and B, each with a
// valid/ready handshake. The arbiter picks the mux input; a one-entry
// registered stage drives the bus (1-cycle latency, 1 word/cycle).
// Build option: ARBITRO_PRIORIDAD_FIJA_EN (fixed priority A over B).
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   DatoA/ValidoA/ListoA     requester A handshake
//   DatoB/ValidoB/ListoB     requester B handshake
//   Salida/ValidoSalida      registered output word and its valid
//   ListoSalida              consumer accepts Salida this cycle
//   Sel                      current grant, 1 = A, 0 = B
module arbitro_mux_2a1
  import arbitro_pkg::*;
#(
  parameter int DB         = 16,
  parameter int MAX_RAFAGA = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DB-1:0] DatoA,
  input  logic          ValidoA,
  output logic          ListoA,
  input  logic [DB-1:0] DatoB,
  input  logic          ValidoB,
  output logic          ListoB,
  output logic [DB-1:0] Salida,
  output logic          ValidoSalida,
  input  logic          ListoSalida,
  output logic          Sel
);

  estado_t       estado;
  logic          libre_sal;
  logic          transfer;
  logic [DB-1:0] dato_mux;

  // The output register can take a word when empty or being drained now.
  assign libre_sal = !ValidoSalida | ListoSalida;
  assign ListoA    = (estado == SERVIR_A) & libre_sal;
  assign ListoB    = (estado == SERVIR_B) & libre_sal;
  assign transfer  = (ValidoA & ListoA) | (ValidoB & ListoB);
  assign dato_mux  = (Sel == SEL_A) ? DatoA : DatoB;

  arbitro_rr_2 #(
    .MAX_RAFAGA(MAX_RAFAGA)
  ) u_arbitro (
    .clk      (clk),
    .reset    (reset),
    .valido_a (ValidoA),
    .valido_b (ValidoB),
    .libre_sal(libre_sal),
    .estado   (estado),
    .sel      (Sel)
  );

  // Output stage: mux -> registered bus word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Salida       <= '0;
      ValidoSalida <= 1'b0;
    end else if (transfer) begin
      Salida       <= dato_mux;
      ValidoSalida <= 1'b1;
    end else if (ListoSalida) begin
      ValidoSalida <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbitro_mux_2a1.sv
// Scoreboard bench for arbitro_mux_2a1: two queue-backed sources, expected
// bus words pushed per scenario and popped as the bus delivers them.
module tb_arbitro_mux_2a1;

  localparam int DB  = 16;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] DatoA, DatoB, Salida;
  logic          ValidoA, ListoA, ValidoB, ListoB;
  logic          ValidoSalida, ListoSalida, Sel;

  always #5 clk = ~clk;

  arbitro_mux_2a1 #(.DB(DB), .MAX_RAFAGA(MAX)) dut (
    .clk(clk), .reset(reset),
    .DatoA(DatoA), .ValidoA(ValidoA), .ListoA(ListoA),
    .DatoB(DatoB), .ValidoB(ValidoB), .ListoB(ListoB),
    .Salida(Salida), .ValidoSalida(ValidoSalida), .ListoSalida(ListoSalida),
    .Sel(Sel)
  );

  int            n_chk = 0;
  int            n_pass = 0;
  logic [DB-1:0] esperado[$];
  int            out_cyc[$];
  int            cyc;
  logic [DB-1:0] a_base, b_base;
  int            a_idx, a_n, b_idx, b_n;
  int            stall_ini, stall_len;
  logic [DB-1:0] congelado;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
  endtask

  task automatic conducir();
    ValidoA     = (a_idx < a_n);
    DatoA       = a_base + DB'(a_idx);
    ValidoB     = (b_idx < b_n);
    DatoB       = b_base + DB'(b_idx);
    ListoSalida = !(cyc >= stall_ini && cyc < stall_ini + stall_len);
  endtask

  task automatic ciclo();
    bit acc_a, acc_b;
    @(negedge clk);
    acc_a = ValidoA && ListoA;
    acc_b = ValidoB && ListoB;
    chk("listo_ambos", ListoA & ListoB, 0);
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    chk("listo_b_con_a", ListoB & ValidoA, 0);
`endif
    if (ListoA || ListoB) chk("sel", Sel, ListoA);
    if (cyc == stall_ini) congelado = Salida;
    if (cyc >= stall_ini && cyc < stall_ini + stall_len) begin
      chk("stall_listo_a", ListoA, 0);
      chk("stall_valido", ValidoSalida, 1);
      chk("stall_salida", Salida, congelado);
    end
    if (ValidoSalida && ListoSalida) begin
      if (esperado.size() == 0) chk("salida_extra", Salida, 32'hFFFF_FFFF);
      else chk("salida", Salida, esperado.pop_front());
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc_a) a_idx++;
    if (acc_b) b_idx++;
    conducir();
  endtask

  task automatic iniciar();
    reset     = 1'b1;
    a_idx = 0; a_n = 0; b_idx = 0; b_n = 0;
    a_base = '0; b_base = '0;
    stall_ini = -100; stall_len = 0; cyc = 0;
    conducir();
    @(posedge clk);
    #1;
    reset = 1'b0;
    esperado.delete();
    out_cyc.delete();
    cyc = 0;
  endtask

  task automatic esperar(input int presupuesto);
    int k = 0;
    while (esperado.size() != 0 && k < presupuesto) begin
      ciclo();
      k++;
    end
    chk("timeout_pendientes", esperado.size(), 0);
    repeat (3) ciclo();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_salida"}, Salida, 0);
    chk({tag, "_valido_salida"}, ValidoSalida, 0);
    chk({tag, "_listo_a"}, ListoA, 0);
    chk({tag, "_listo_b"}, ListoB, 0);
    chk({tag, "_sel"}, Sel, 0);
  endtask

  initial begin
    reset = 1'b1;
    a_idx = 0; a_n = 0; b_idx = 0; b_n = 0;
    a_base = '0; b_base = '0;
    stall_ini = -100; stall_len = 0; cyc = 0;
    conducir();
    #1;
    chk_reset("rst_inicial");

    // Reset in the middle of an A burst
    iniciar();
    a_base = 16'h0001; a_n = 6;
    conducir();
    esperado.push_back(16'h0001);
    repeat (3) ciclo();
    chk("rst_pendiente", esperado.size(), 0);
    reset = 1'b1;
    #1;
    chk_reset("rst_medio");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    out_cyc.delete();
    b_base = 16'hB000; b_n = 4;
    conducir();
    for (int k = 3; k <= 6; k++) esperado.push_back(DB'(k));
    for (int k = 0; k < 4; k++) esperado.push_back(16'hB000 + DB'(k));
    esperar(40);
    chk("rst_a_primero_cyc", out_cyc[0], 2);

    // Both requesters continuously valid
    iniciar();
    a_base = 16'hA000; a_n = 12;
    b_base = 16'hB000; b_n = 12;
    conducir();
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    for (int k = 0; k < 12; k++) esperado.push_back(16'hA000 + DB'(k));
    for (int k = 0; k < 12; k++) esperado.push_back(16'hB000 + DB'(k));
`else
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) esperado.push_back(16'hA000 + DB'(4 * r + k));
      for (int k = 0; k < 4; k++) esperado.push_back(16'hB000 + DB'(4 * r + k));
    end
`endif
    esperar(100);
    chk("empate_n", out_cyc.size(), 24);
    chk("empate_primera", out_cyc[0], 2);
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    chk("empate_tramo", out_cyc[23] - out_cyc[0], 24);
`else
    chk("empate_tramo", out_cyc[23] - out_cyc[0], 23);
`endif

    // Single requester B, 10 words across burst limits
    iniciar();
    b_base = 16'hB000; b_n = 10;
    conducir();
    for (int k = 0; k < 10; k++) esperado.push_back(16'hB000 + DB'(k));
    esperar(60);
    chk("solo_b_n", out_cyc.size(), 10);
    chk("solo_b_primera", out_cyc[0], 2);
    chk("solo_b_tramo", out_cyc[9] - out_cyc[0], 9);

    // Consumer backpressure for 5 cycles mid-burst
    iniciar();
    a_base = 16'hA000; a_n = 8;
    stall_ini = 4; stall_len = 5;
    conducir();
    for (int k = 0; k < 8; k++) esperado.push_back(16'hA000 + DB'(k));
    esperar(60);
    chk("stall_n", out_cyc.size(), 8);
    chk("stall_congelado", congelado, 16'hA002);

    // A drops valid after 2 words while B waits
    iniciar();
    a_base = 16'hA000; a_n = 2;
    b_base = 16'hB000; b_n = 3;
    conducir();
    esperado.push_back(16'hA000);
    esperado.push_back(16'hA001);
    for (int k = 0; k < 3; k++) esperado.push_back(16'hB000 + DB'(k));
    esperar(40);
    chk("caida_n", out_cyc.size(), 5);
    chk("caida_b0_cyc", out_cyc[2], 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
